// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM demultiplexer slice.
//   state_t          : receiver state (HUNT = searching for frame marker,
//                      COLLECT = frame-locked, gathering slots)
//   TDM_N_SLOTS_DEF  : default number of data slots per frame
//   TDM_SLOT_W       : slot-counter width for the default slot count
//   frame_len()      : slots per frame including the optional parity slot
// Optional feature macro: TDM_PARITY_EN (adds one even-parity slot per frame).
// ---------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int TDM_N_SLOTS_DEF = 8;

    // Counter must be able to hold N_SLOTS itself (parity slot index).
    localparam int TDM_SLOT_W = $clog2(TDM_N_SLOTS_DEF + 1);

    function automatic int frame_len(input int n_slots);
`ifdef TDM_PARITY_EN
        return n_slots + 1;
`else
        return n_slots;
`endif
    endfunction

endpackage

// File: rtl/tdm_demux8_if.sv
// ---------------------------------------------------------------------------
// tdm_demux8_if
// Bundles the serial input and parallel output signals of tdm_demux8.
//   iEn       : slot strobe (iD/iSync only meaningful while high)
//   iD        : serial slot data
//   iSync     : frame marker, high on slot 0
//   oQ        : last complete frame, slot k on oQ[k]
//   oValid    : one-cycle pulse when oQ updates
//   oLock     : receiver frame-locked
//   oSlot     : index of the next expected slot
//   oSyncErr  : one-cycle pulse on a sync violation
//   oParErr   : one-cycle pulse on a parity mismatch (TDM_PARITY_EN only)
// Modports: master = stream source / frame consumer, slave = demultiplexer.
// Optional feature macro: TDM_PARITY_EN.
// ---------------------------------------------------------------------------
interface tdm_demux8_if #(
    parameter int N_SLOTS = tdm_pkg::TDM_N_SLOTS_DEF
);
    localparam int SLOT_W = $clog2(N_SLOTS + 1);

    logic               iEn;
    logic               iD;
    logic               iSync;
    logic [N_SLOTS-1:0] oQ;
    logic               oValid;
    logic               oLock;
    logic [SLOT_W-1:0]  oSlot;
    logic               oSyncErr;
`ifdef TDM_PARITY_EN
    logic               oParErr;
`endif

`ifdef TDM_PARITY_EN
    modport master (
        output iEn, iD, iSync,
        input  oQ, oValid, oLock, oSlot, oSyncErr, oParErr
    );

    modport slave (
        input  iEn, iD, iSync,
        output oQ, oValid, oLock, oSlot, oSyncErr, oParErr
    );
`else
    modport master (
        output iEn, iD, iSync,
        input  oQ, oValid, oLock, oSlot, oSyncErr
    );

    modport slave (
        input  iEn, iD, iSync,
        output oQ, oValid, oLock, oSlot, oSyncErr
    );
`endif

endinterface

// File: rtl/tdm_slot_ctr.sv
// ---------------------------------------------------------------------------
// tdm_slot_ctr
// Enable-gated slot counter for the TDM receiver.
//   iClk   : clock, rising edge
//   iRst   : asynchronous active-high reset (counter -> 0)
//   iAdv   : advance one slot (wraps LAST -> 0)
//   iLoad1 : synchronous load to 1; used when a slot-0 sample starts a frame,
//            has priority over iAdv
//   oSlot  : current slot index (next slot to be sampled)
//   oWrap  : counter sits on the final slot, so the next advance wraps
// ---------------------------------------------------------------------------
module tdm_slot_ctr #(
    parameter int LAST = 7,
    parameter int W    = $clog2(LAST + 2)
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iAdv,
    input  logic         iLoad1,
    output logic [W-1:0] oSlot,
    output logic         oWrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Level indication only: it must not depend on iAdv, because the
    // controller uses it to decide whether to advance.
    assign oWrap = (cnt_q == W'(LAST));
    assign oSlot = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (iLoad1) begin
            cnt_d = W'(1);
        end else if (iAdv) begin
            cnt_d = oWrap ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// ---------------------------------------------------------------------------
// tdm_demux8
// Serial time-division demultiplexer. Slot k of each frame is collected into
// bit k of a shift register; the edge that samples the final slot publishes
// the frame on oQ with a one-cycle oValid pulse. Frame-lock is acquired on
// iSync and lost when slot 0 arrives without iSync. An iSync in the middle
// of a frame restarts the frame and flags oSyncErr.
// Ports:
//   iClk : clock, rising edge
//   iRst : asynchronous active-high reset
//   bus  : tdm_demux8_if.slave (iEn, iD, iSync in; oQ, oValid, oLock, oSlot,
//          oSyncErr, and oParErr with TDM_PARITY_EN, out)
// Optional feature macro: TDM_PARITY_EN -- each frame carries an extra slot
// (index N_SLOTS) with even parity over the data slots; a mismatch drops the
// frame and pulses oParErr instead of oValid.
// ---------------------------------------------------------------------------
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int N_SLOTS = TDM_N_SLOTS_DEF
) (
    input  logic          iClk,
    input  logic          iRst,
    tdm_demux8_if.slave   bus
);

    localparam int SLOT_W    = $clog2(N_SLOTS + 1);
    localparam int FRAME_LEN = frame_len(N_SLOTS);
    localparam int LAST      = FRAME_LEN - 1;

    state_t             state_q, state_d;
    logic [N_SLOTS-1:0] sh_q, sh_d;
    logic [N_SLOTS-1:0] q_q, q_d;
    logic               valid_q, valid_d;
    logic               sync_err_q, sync_err_d;
`ifdef TDM_PARITY_EN
    logic               par_err_q, par_err_d;
`endif

    logic [SLOT_W-1:0]  slot;
    logic               at_last;
    logic               ctr_adv;
    logic               ctr_load1;

    logic [N_SLOTS-1:0] sh_ins;    // shift register with iD placed at the current slot
    logic [N_SLOTS-1:0] sh_first;  // fresh frame holding only slot 0

    tdm_slot_ctr #(
        .LAST (LAST),
        .W    (SLOT_W)
    ) u_slot_ctr (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAdv   (ctr_adv),
        .iLoad1 (ctr_load1),
        .oSlot  (slot),
        .oWrap  (at_last)
    );

    assign sh_first = {{(N_SLOTS-1){1'b0}}, bus.iD};

    // Decoded write into the slot position. The parity slot (index N_SLOTS)
    // matches no data bit and leaves the register untouched.
    always_comb begin
        sh_ins = sh_q;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot == SLOT_W'(k)) begin
                sh_ins[k] = bus.iD;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        q_d        = q_q;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;
`ifdef TDM_PARITY_EN
        par_err_d  = 1'b0;
`endif
        ctr_adv    = 1'b0;
        ctr_load1  = 1'b0;

        case (state_q)
            HUNT: begin
                if (bus.iEn && bus.iSync) begin
                    sh_d      = sh_first;
                    ctr_load1 = 1'b1;
                    state_d   = COLLECT;
                end
            end

            COLLECT: begin
                if (bus.iEn) begin
                    if (bus.iSync) begin
                        // Marker always starts a new frame. Anywhere but slot 0
                        // (final slot included) the partial frame is dropped.
                        sh_d      = sh_first;
                        ctr_load1 = 1'b1;
                        if (slot != '0) begin
                            sync_err_d = 1'b1;
                        end
                    end else if (slot == '0) begin
                        // Slot 0 without its marker: lock is lost, bit dropped.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else if (at_last) begin
                        ctr_adv = 1'b1;
`ifdef TDM_PARITY_EN
                        if ((^sh_q) == bus.iD) begin
                            q_d     = sh_q;
                            valid_d = 1'b1;
                        end else begin
                            par_err_d = 1'b1;
                        end
`else
                        q_d     = sh_ins;
                        valid_d = 1'b1;
`endif
                    end else begin
                        sh_d    = sh_ins;
                        ctr_adv = 1'b1;
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= HUNT;
            sh_q       <= '0;
            q_q        <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
`ifdef TDM_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            q_q        <= q_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
`ifdef TDM_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign bus.oQ       = q_q;
    assign bus.oValid   = valid_q;
    assign bus.oLock    = (state_q == COLLECT);
    assign bus.oSlot    = slot;
    assign bus.oSyncErr = sync_err_q;
`ifdef TDM_PARITY_EN
    assign bus.oParErr  = par_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux8
// Directed and randomized stimulus for tdm_demux8, checked every cycle
// against a queue-based frame model.
// ---------------------------------------------------------------------------
module tb_tdm_demux8;

    localparam int N = 8;
`ifdef TDM_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tdm_demux8_if #(.N_SLOTS(N)) bus ();

    tdm_demux8 #(.N_SLOTS(N)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: a frame is the list of bits received since the marker.
    bit         mbits[$];
    logic       m_lock;
    logic [N-1:0] m_q;
    logic       m_valid;
    logic       m_err;
    logic       m_par;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mbits.delete();
        m_lock  = 1'b0;
        m_q     = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_par   = 1'b0;
    endtask

    task automatic model_sample(input logic d, input logic sync);
        int ones;
        logic [N-1:0] acc;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_par   = 1'b0;
        if (!m_lock) begin
            if (sync) begin
                m_lock = 1'b1;
                mbits  = {d};
            end
        end else if (sync) begin
            if (mbits.size() != 0) m_err = 1'b1;
            mbits = {d};
        end else if (mbits.size() == 0) begin
            m_err  = 1'b1;
            m_lock = 1'b0;
        end else begin
            mbits.push_back(d);
            if (mbits.size() == FL) begin
                ones = 0;
                foreach (mbits[i]) ones += int'(mbits[i]);
                if (FL > N && (ones % 2) != 0) begin
                    m_par = 1'b1;
                end else begin
                    acc = '0;
                    for (int i = 0; i < N; i++) acc = acc | (N'(mbits[i]) << i);
                    m_q     = acc;
                    m_valid = 1'b1;
                end
                mbits.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_q"},     32'(bus.oQ),       32'(m_q));
        chk({tag, "_valid"}, 32'(bus.oValid),   32'(m_valid));
        chk({tag, "_lock"},  32'(bus.oLock),    32'(m_lock));
        chk({tag, "_slot"},  32'(bus.oSlot),    32'(mbits.size()));
        chk({tag, "_serr"},  32'(bus.oSyncErr), 32'(m_err));
        chk({tag, "_excl"},  32'(bus.oValid & bus.oSyncErr), 32'd0);
`ifdef TDM_PARITY_EN
        chk({tag, "_perr"},  32'(bus.oParErr),  32'(m_par));
`endif
    endtask

    task automatic step(input logic en, input logic d, input logic sync, input string tag);
        @(negedge clk);
        bus.iEn   = en;
        bus.iD    = d;
        bus.iSync = sync;
        @(posedge clk);
        if (en) begin
            model_sample(d, sync);
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_par   = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    function automatic logic frame_bit(input logic [N-1:0] data, input int i, input logic flip);
        logic [N-1:0] t;
        if (i < N) begin
            t = data >> i;
            return t[0];
        end
        return (^data) ^ flip;
    endfunction

    // Gaps carry random iD/iSync with iEn low; they must be ignored.
    task automatic send_frame(input logic [N-1:0] data, input bit gaps, input logic flip, input string tag);
        for (int i = 0; i < FL; i++) begin
            if (gaps) step(1'b0, 1'($urandom), 1'($urandom), {tag, "_gap"});
            step(1'b1, frame_bit(data, i, flip), (i == 0), tag);
        end
    endtask

    initial begin
        model_reset();
        rst       = 1'b1;
        bus.iEn   = 1'b0;
        bus.iD    = 1'b0;
        bus.iSync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: continuous 0xA5 frame
        send_frame(8'hA5, 1'b0, 1'b0, "t1");
        chk("t1_q_const", 32'(bus.oQ), 32'hA5);
        chk("t1_valid_hi", 32'(bus.oValid), 32'd1);
        chk("t1_lock_hi", 32'(bus.oLock), 32'd1);
        step(1'b0, 1'b0, 1'b0, "t1_idle");
        chk("t1_valid_lo", 32'(bus.oValid), 32'd0);

        // 2: same frame with idle gaps between slots
        send_frame(8'hA5, 1'b1, 1'b0, "t2");
        chk("t2_q_const", 32'(bus.oQ), 32'hA5);
        chk("t2_valid_hi", 32'(bus.oValid), 32'd1);

        // 3: partial 0x3C, marker reasserted at slot 5, then full 0xC3
        for (int i = 0; i < 5; i++) step(1'b1, frame_bit(8'h3C, i, 1'b0), (i == 0), "t3_part");
        step(1'b1, frame_bit(8'hC3, 0, 1'b0), 1'b1, "t3_resync");
        chk("t3_serr_hi", 32'(bus.oSyncErr), 32'd1);
        chk("t3_slot1", 32'(bus.oSlot), 32'd1);
        chk("t3_q_held", 32'(bus.oQ), 32'hA5);
        for (int i = 1; i < FL; i++) step(1'b1, frame_bit(8'hC3, i, 1'b0), 1'b0, "t3_full");
        chk("t3_q_const", 32'(bus.oQ), 32'hC3);

        // 4: good 0x0F then slot 0 without marker -> lock lost
        send_frame(8'h0F, 1'b0, 1'b0, "t4_good");
        step(1'b1, 1'b1, 1'b0, "t4_nosync");
        chk("t4_serr_hi", 32'(bus.oSyncErr), 32'd1);
        chk("t4_lock_lo", 32'(bus.oLock), 32'd0);
        for (int i = 0; i < N; i++) step(1'b1, 1'($urandom), 1'b0, "t4_ignored");
        chk("t4_q_held", 32'(bus.oQ), 32'h0F);
        send_frame(8'h5A, 1'b0, 1'b0, "t4_relock");

        // 5: asynchronous reset mid-frame at slot 4
        for (int i = 0; i < 4; i++) step(1'b1, frame_bit(8'h66, i, 1'b0), (i == 0), "t5_part");
        chk("t5_slot4", 32'(bus.oSlot), 32'd4);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("t5_rst");
        chk("t5_q_zero", 32'(bus.oQ), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, "t5_recover");
        chk("t5_q_const", 32'(bus.oQ), 32'h81);

`ifdef TDM_PARITY_EN
        // 6: parity good, then parity bad
        send_frame(8'h07, 1'b0, 1'b0, "t6_good");
        chk("t6_valid_hi", 32'(bus.oValid), 32'd1);
        chk("t6_q_const", 32'(bus.oQ), 32'h07);
        send_frame(8'h07, 1'b0, 1'b1, "t6_bad");
        chk("t6_perr_hi", 32'(bus.oParErr), 32'd1);
        chk("t6_valid_lo", 32'(bus.oValid), 32'd0);
        chk("t6_q_held", 32'(bus.oQ), 32'h07);
        chk("t6_lock_kept", 32'(bus.oLock), 32'd1);
`endif

        // Randomized traffic: markers mostly land on slot 0, occasionally early
        for (int c = 0; c < 800; c++) begin
            logic en, d, sy;
            en = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom);
            if (mbits.size() == 0) sy = ($urandom_range(0, 7) != 0);
            else                   sy = ($urandom_range(0, 15) == 0);
            step(en, d, sy, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
